ps2_keymatrix: RTL and testbench



---
 rtl/cobra1_kb_pkg.sv | 57 +++++
 rtl/ps2_rx.sv | 140 ++++++++++++++
 rtl/ps2_keymatrix.sv | 94 +++++++++
 tb/tb_ps2_keymatrix.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobra1_kb_pkg.sv
// Shared types and constants for the Cobra1 PS/2 keyboard front end,
// including the set-2 scan code to 5x8 switch-matrix mapping.
package cobra1_kb_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   localparam int         KB_KEYS  = 40;
   localparam logic [5:0] KEY_NONE = 6'd63;

   localparam logic [7:0] BYTE_E0 = 8'hE0;
   localparam logic [7:0] BYTE_F0 = 8'hF0;
   localparam logic [7:0] BYTE_E1 = 8'hE1;
   localparam logic [7:0] BYTE_AA = 8'hAA;
   localparam logic [7:0] BYTE_FC = 8'hFC;
   localparam logic [7:0] BYTE_FF = 8'hFF;
   localparam logic [7:0] BYTE_00 = 8'h00;

   // Matrix rows of five: SHIFT Z X C V / A S D F G / 1 2 3 4 5 / Q W E R T /
   // 0 9 8 7 6 / P O I U Y / ENTER L K J H / SPACE . M N B
   function automatic logic [5:0] map_key(input logic ext, input logic [7:0] code);
      map_key = KEY_NONE;
      if (ext) begin
         if (code == 8'h5A) map_key = 6'd30;
      end else begin
         case (code)
            8'h12, 8'h59: map_key = 6'd0;
            8'h1A: map_key = 6'd1;   8'h22: map_key = 6'd2;
            8'h21: map_key = 6'd3;   8'h2A: map_key = 6'd4;
            8'h1C: map_key = 6'd5;   8'h1B: map_key = 6'd6;
            8'h23: map_key = 6'd7;   8'h2B: map_key = 6'd8;
            8'h34: map_key = 6'd9;   8'h16: map_key = 6'd10;
            8'h1E: map_key = 6'd11;  8'h26: map_key = 6'd12;
            8'h25: map_key = 6'd13;  8'h2E: map_key = 6'd14;
            8'h15: map_key = 6'd15;  8'h1D: map_key = 6'd16;
            8'h24: map_key = 6'd17;  8'h2D: map_key = 6'd18;
            8'h2C: map_key = 6'd19;  8'h45: map_key = 6'd20;
            8'h46: map_key = 6'd21;  8'h3E: map_key = 6'd22;
            8'h3D: map_key = 6'd23;  8'h36: map_key = 6'd24;
            8'h4D: map_key = 6'd25;  8'h44: map_key = 6'd26;
            8'h43: map_key = 6'd27;  8'h3C: map_key = 6'd28;
            8'h35: map_key = 6'd29;  8'h5A: map_key = 6'd30;
            8'h4B: map_key = 6'd31;  8'h42: map_key = 6'd32;
            8'h3B: map_key = 6'd33;  8'h33: map_key = 6'd34;
            8'h29: map_key = 6'd35;  8'h49: map_key = 6'd36;
            8'h3A: map_key = 6'd37;  8'h31: map_key = 6'd38;
            8'h32: map_key = 6'd39;
            default: map_key = KEY_NONE;
         endcase
      end
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, clock deglitch filter, 11-bit frame
// FSM with odd-parity/stop checking and an in-frame idle timeout.
module ps2_rx
   import cobra1_kb_pkg::*;
#(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       scan_valid,
   output logic [7:0] scan_code,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]          clk_sync_q;
   logic [1:0]          dat_sync_q;
   logic [FILT_LEN-1:0] filt_sh_q;
   logic                filt_lvl_q, filt_lvl_d;
   logic                fall_evt;
   logic                dat_smp;

   rx_state_e           state_q, state_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          shift_q, shift_d;
   logic                par_q, par_d;
   logic [CNT_W-1:0]    tmo_q, tmo_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic [7:0]          code_q, code_d;

   // Idle PS/2 lines are high, so the front end resets to all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         filt_sh_q  <= '1;
         filt_lvl_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_dat};
         filt_sh_q  <= {filt_sh_q[FILT_LEN-2:0], clk_sync_q[1]};
         filt_lvl_q <= filt_lvl_d;
      end
   end

   always_comb begin
      filt_lvl_d = filt_lvl_q;
      if (&filt_sh_q)      filt_lvl_d = 1'b1;
      else if (~|filt_sh_q) filt_lvl_d = 1'b0;
   end

   assign fall_evt = filt_lvl_q & ~filt_lvl_d;
   assign dat_smp  = dat_sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RX_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tmo_d     = tmo_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;

      if (fall_evt) begin
         tmo_d = '0;
         unique case (state_q)
            RX_IDLE: begin
               if (!dat_smp) begin
                  state_d   = RX_DATA;
                  bit_cnt_d = '0;
               end
            end
            RX_DATA: begin
               shift_d   = {dat_smp, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
            end
            RX_PARITY: begin
               par_d   = dat_smp;
               state_d = RX_STOP;
            end
            RX_STOP: begin
               state_d = RX_IDLE;
               if (dat_smp && (^{shift_q, par_q})) begin
                  valid_d = 1'b1;
                  code_d  = shift_q;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end else if (state_q != RX_IDLE) begin
         // An event in the same cycle takes priority over the timeout.
         if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
            shift_d = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   assign scan_valid = valid_q;
   assign scan_code  = code_q;
   assign frame_err  = err_q;

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard to Cobra1 40-bit switch matrix: receives scan codes and
// decodes set-2 make/break/extended/pause sequences into held-key bits.
module ps2_keymatrix
   import cobra1_kb_pkg::*;
#(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_dat,
   output logic [39:0]  kb_state,
   output logic         scan_valid,
   output logic [7:0]   scan_code,
   output logic         frame_err
);

   logic        rx_valid;
   logic [7:0]  rx_code;
   logic        rx_err;

   logic        ext_q, ext_d;
   logic        brk_q, brk_d;
   logic [2:0]  skip_q, skip_d;
   logic [39:0] kb_q, kb_d;
   logic [5:0]  key_idx;

   ps2_rx #(
      .FILT_LEN    (FILT_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_dat    (ps2_dat),
      .scan_valid (rx_valid),
      .scan_code  (rx_code),
      .frame_err  (rx_err)
   );

   assign key_idx = map_key(ext_q, rx_code);

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
         skip_q <= '0;
         kb_q   <= '0;
      end else begin
         ext_q  <= ext_d;
         brk_q  <= brk_d;
         skip_q <= skip_d;
         kb_q   <= kb_d;
      end
   end

   always_comb begin
      ext_d  = ext_q;
      brk_d  = brk_q;
      skip_d = skip_q;
      kb_d   = kb_q;

      if (rx_valid) begin
         // Pause sends E1 plus seven bytes that must not touch the matrix.
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
         end else begin
            case (rx_code)
               BYTE_E0: ext_d  = 1'b1;
               BYTE_F0: brk_d  = 1'b1;
               BYTE_E1: skip_d = 3'd7;
               BYTE_AA, BYTE_FC, BYTE_00, BYTE_FF: begin
                  kb_d  = '0;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
               default: begin
                  if (key_idx != KEY_NONE && key_idx < 6'(KB_KEYS))
                     kb_d[key_idx] = ~brk_q;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            endcase
         end
      end
   end

   assign kb_state   = kb_q;
   assign scan_valid = rx_valid;
   assign scan_code  = rx_code;
   assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Scoreboard bench for ps2_keymatrix: directed protocol cases plus random
// key activity checked against a held-key model of the switch matrix.
module tb_ps2_keymatrix;

   localparam int HALF = 20;
   localparam int GAP  = 40;

   typedef struct {
      bit          is_valid;
      logic [7:0]  code;
      logic [39:0] kb;
   } exp_t;

   typedef struct {
      logic [7:0] code;
      bit         ext;
      int         idx;
   } key_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic [39:0] kb_state;
   logic        scan_valid;
   logic [7:0]  scan_code;
   logic        frame_err;

   exp_t        sb[$];
   logic [39:0] model_kb = '0;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_out = 0;
   time         t_err = 0;
   time         t_last = 0;

   key_t keys [0:14] = '{
      '{8'h12, 1'b0, 0},  '{8'h59, 1'b0, 0},  '{8'h1C, 1'b0, 5},
      '{8'h1B, 1'b0, 6},  '{8'h1A, 1'b0, 1},  '{8'h16, 1'b0, 10},
      '{8'h2E, 1'b0, 14}, '{8'h15, 1'b0, 15}, '{8'h45, 1'b0, 20},
      '{8'h4D, 1'b0, 25}, '{8'h5A, 1'b0, 30}, '{8'h5A, 1'b1, 30},
      '{8'h33, 1'b0, 34}, '{8'h29, 1'b0, 35}, '{8'h32, 1'b0, 39}
   };

   ps2_keymatrix #(
      .FILT_LEN    (4),
      .TIMEOUT_CYC (200)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_dat    (ps2_dat),
      .kb_state   (kb_state),
      .scan_valid (scan_valid),
      .scan_code  (scan_code),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bit-level frame driver; pins change on the falling clk edge.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_dat = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic send_ok(input logic [7:0] b);
      sb.push_back('{1'b1, b, model_kb});
      send_frame(b, 1'b0, 1'b0);
   endtask

   task automatic send_bad(input logic [7:0] b, input bit bp, input bit bs);
      sb.push_back('{1'b0, 8'h00, model_kb});
      send_frame(b, bp, bs);
   endtask

   task automatic press(input key_t k);
      if (k.ext) send_ok(8'hE0);
      model_kb[k.idx] = 1'b1;
      send_ok(k.code);
   endtask

   task automatic release_key(input key_t k);
      if (k.ext) send_ok(8'hE0);
      send_ok(8'hF0);
      model_kb[k.idx] = 1'b0;
      send_ok(k.code);
   endtask

   task automatic pause_seq();
      logic [7:0] seq [0:7];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send_ok(seq[i]);
   endtask

   task automatic partial_frame(input int nbits);
      logic [3:0] f;
      f = 4'b1010;
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         t_last = $time;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
   endtask

   // Monitor: pops one expectation per output pulse, checks matrix next cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (scan_valid || frame_err)) begin
            n_out++;
            if (frame_err) t_err = $time;
            check("pulse_exclusive", 64'(scan_valid & frame_err), 64'(0));
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: valid=%0b err=%0b code=%h, nothing expected",
                        scan_valid, frame_err, scan_code);
            end else begin
               e = sb.pop_front();
               check("pulse_kind_valid", 64'(scan_valid), 64'(e.is_valid));
               if (e.is_valid) check("scan_code", 64'(scan_code), 64'(e.code));
               @(negedge clk);
               check("pulse_width", 64'(scan_valid | frame_err), 64'(0));
               check("kb_state", 64'(kb_state), 64'(e.kb));
            end
         end
      end
   end

   initial begin
      int r;
      int cyc;
      int seen;
      key_t k;

      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_kb_state", 64'(kb_state), 64'(0));
      check("reset_scan_valid", 64'(scan_valid), 64'(0));
      check("reset_scan_code", 64'(scan_code), 64'(0));
      check("reset_frame_err", 64'(frame_err), 64'(0));
      repeat (20) @(negedge clk);

      // Make and break of 'A'
      press(keys[2]);
      release_key(keys[2]);

      // Both shifts share bit 0; releasing one clears it
      press(keys[0]);
      press(keys[1]);
      release_key(keys[0]);

      // Bad parity, then bad stop bit
      press(keys[3]);
      send_bad(8'h1C, 1'b1, 1'b0);
      send_bad(8'h1C, 1'b0, 1'b1);
      release_key(keys[3]);

      // Truncated frame: start + 3 data bits, then silence
      sb.push_back('{1'b0, 8'h00, model_kb});
      partial_frame(4);
      repeat (260) @(negedge clk);
      cyc = int'((t_err - t_last) / 10);
      n_vec++;
      if (t_err < t_last || cyc < 200 || cyc > 215) begin
         n_err++;
         $display("FAIL timeout_latency: got %0d cycles, expected 200..215", cyc);
      end
      press(keys[13]);

      // Extended enter, fake shift, pause, then '1'
      press(keys[11]);
      release_key(keys[11]);
      send_ok(8'hE0);
      send_ok(8'h12);
      pause_seq();
      press(keys[5]);

      // Self-test byte clears everything held
      press(keys[2]);
      model_kb = '0;
      send_ok(8'hAA);

      // 1 ns clock glitch with data low must not start a frame
      seen = n_out;
      @(negedge clk);
      ps2_dat = 1'b0;
      ps2_clk = 1'b0;
      #1 ps2_clk = 1'b1;
      repeat (40) @(negedge clk);
      ps2_dat = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_no_output", 64'(n_out), 64'(seen));
      press(keys[13]);

      // Reset mid-frame with a pending E0
      send_ok(8'hE0);
      partial_frame(3);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_kb_state", 64'(kb_state), 64'(0));
      check("midrst_scan_valid", 64'(scan_valid), 64'(0));
      check("midrst_scan_code", 64'(scan_code), 64'(0));
      check("midrst_frame_err", 64'(frame_err), 64'(0));
      sb.delete();
      model_kb = '0;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      press(keys[0]);

      // Random key activity
      for (int n = 0; n < 30; n++) begin
         r = int'($urandom_range(0, 19));
         k = keys[$urandom_range(0, 14)];
         if (r < 9)       press(k);
         else if (r < 15) release_key(k);
         else if (r < 17) send_bad(8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
         else if (r == 17) begin
            send_ok(8'hE0);
            send_ok(8'h12);
         end else if (r == 18) pause_seq();
         else begin
            model_kb = '0;
            send_ok(8'hAA);
         end
      end

      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
